// File: rtl/microondas_sequencer.sv
// Microwave cook sequencer: BCD mm:ss keypad entry, 1 Hz countdown, magnetron and beep control.
// Optional QUICK_START_EN: start in IDLE at 0000 loads 0030, start while cooking adds 30 s.
module microondas_sequencer #(
  parameter int DONE_TICKS = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tick_1hz,
  input  logic        i_startn,
  input  logic        i_stopn,
  input  logic        i_clrn,
  input  logic        i_porta_fechada,
  input  logic        i_key_valid,
  input  logic [3:0]  i_key_digit,
  output logic [15:0] o_tempo,
  output logic        o_zero,
  output logic        o_magnetron_on,
  output logic        o_beep,
  output logic        o_cozinhando
);

  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_COOK, S_PAUSE, S_DONE} state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_tempo, w_tempo_next;
  logic [3:0]  r_beep_cnt, w_beep_cnt_next;
  logic        r_startn_d;

  logic        w_start;
  logic        w_tempo_zero;
  logic        w_key_ok;
  logic        w_resume_ok;
  logic        w_quick_idle;
  logic        w_quick_cook;
  logic [15:0] w_tempo_dec;
  logic [15:0] w_tempo_add;

  assign w_start      = r_startn_d & ~i_startn;
  assign w_tempo_zero = (r_tempo == 16'h0000);
  assign w_key_ok     = i_key_valid && (i_key_digit <= 4'd9);
  assign w_resume_ok  = w_start && i_porta_fechada && !w_tempo_zero;

  // Seconds are decremented digit-wise, so entries like 0099 count down literally
  always_comb begin
    w_tempo_dec = r_tempo;
    w_tempo_dec[3:0] = (r_tempo[3:0] == 4'd0) ? 4'd9 : r_tempo[3:0] - 4'd1;
    if (r_tempo[3:0] == 4'd0) begin
      w_tempo_dec[7:4] = (r_tempo[7:4] == 4'd0) ? 4'd5 : r_tempo[7:4] - 4'd1;
      if (r_tempo[7:4] == 4'd0) begin
        w_tempo_dec[11:8] = (r_tempo[11:8] == 4'd0) ? 4'd9 : r_tempo[11:8] - 4'd1;
        if (r_tempo[11:8] == 4'd0) begin
          w_tempo_dec[15:12] = r_tempo[15:12] - 4'd1;
        end
      end
    end
  end

`ifdef QUICK_START_EN
  logic [3:0] w_sec_tens_sum;

  assign w_quick_idle = w_start && i_porta_fechada && w_tempo_zero;
  assign w_quick_cook = w_start && i_porta_fechada;

  // +30 s lands on the seconds-tens digit; the carry into minutes saturates at 99:59
  always_comb begin
    w_tempo_add    = r_tempo;
    w_sec_tens_sum = r_tempo[7:4] + 4'd3;
    if (w_sec_tens_sum >= 4'd6) begin
      w_tempo_add[7:4] = w_sec_tens_sum - 4'd6;
      if (r_tempo[15:8] == 8'h99) begin
        w_tempo_add = 16'h9959;
      end else if (r_tempo[11:8] == 4'd9) begin
        w_tempo_add[11:8]  = 4'd0;
        w_tempo_add[15:12] = r_tempo[15:12] + 4'd1;
      end else begin
        w_tempo_add[11:8] = r_tempo[11:8] + 4'd1;
      end
    end else begin
      w_tempo_add[7:4] = w_sec_tens_sum;
    end
  end
`else
  assign w_quick_idle = 1'b0;
  assign w_quick_cook = 1'b0;
  assign w_tempo_add  = r_tempo;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_tempo_next    = r_tempo;
    w_beep_cnt_next = 4'd0;
    if (!i_clrn) begin
      w_state_next = S_IDLE;
      w_tempo_next = 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_quick_idle) begin
            w_tempo_next = 16'h0030;
            w_state_next = S_COOK;
          end else if (w_key_ok) begin
            w_tempo_next = {r_tempo[11:0], i_key_digit};
            w_state_next = S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (w_resume_ok) begin
            w_state_next = S_COOK;
          end else if (w_key_ok) begin
            w_tempo_next = {r_tempo[11:0], i_key_digit};
          end
        end
        S_COOK: begin
          if (!i_stopn) begin
            w_state_next = S_PAUSE;
          end else if (w_quick_cook) begin
            w_tempo_next = w_tempo_add;
          end else if (!i_porta_fechada) begin
            w_state_next = S_PAUSE;
          end else if (i_tick_1hz) begin
            w_tempo_next = w_tempo_dec;
            if (w_tempo_dec == 16'h0000) begin
              w_state_next = S_DONE;
            end
          end
        end
        S_PAUSE: begin
          if (w_resume_ok) begin
            w_state_next = S_COOK;
          end
        end
        S_DONE: begin
          w_beep_cnt_next = r_beep_cnt;
          if (i_tick_1hz) begin
            if (r_beep_cnt == 4'(DONE_TICKS - 1)) begin
              w_beep_cnt_next = 4'd0;
              w_state_next    = S_IDLE;
            end else begin
              w_beep_cnt_next = r_beep_cnt + 4'd1;
            end
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_tempo    <= 16'h0000;
      r_beep_cnt <= 4'd0;
      r_startn_d <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_tempo    <= w_tempo_next;
      r_beep_cnt <= w_beep_cnt_next;
      r_startn_d <= i_startn;
    end
  end

  assign o_tempo        = r_tempo;
  assign o_zero         = w_tempo_zero;
  assign o_magnetron_on = (r_state == S_COOK);
  assign o_beep         = (r_state == S_DONE);
  assign o_cozinhando   = (r_state == S_COOK) || (r_state == S_PAUSE);

endmodule

// File: tb/tb_microondas_sequencer.sv
// Self-checking bench for microondas_sequencer: directed scenarios plus randomized episodes
// compared against a minutes/seconds reference model (honours QUICK_START_EN when defined).
module tb_microondas_sequencer;

  localparam int DONE_TICKS = 3;

  typedef enum {M_IDLE, M_ENTRY, M_COOK, M_PAUSE, M_DONE} modelMode_t;

  logic        clk = 1'b0;
  logic        rst, tick, startn, stopn, clrn, door, keyValid;
  logic [3:0]  keyDigit;
  logic [15:0] tempo;
  logic        zero, magnetronOn, beep, cozinhando;

  int testsRun = 0;
  int testsFailed = 0;

  modelMode_t mMode;
  int         mMin, mSec, mBeepCnt;
  logic       mPrevStartn;

  microondas_sequencer #(.DONE_TICKS(DONE_TICKS)) dut (
    .i_clk(clk), .i_rst(rst), .i_tick_1hz(tick), .i_startn(startn), .i_stopn(stopn),
    .i_clrn(clrn), .i_porta_fechada(door), .i_key_valid(keyValid), .i_key_digit(keyDigit),
    .o_tempo(tempo), .o_zero(zero), .o_magnetron_on(magnetronOn), .o_beep(beep),
    .o_cozinhando(cozinhando)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference model works in whole minutes/seconds, one step per clock edge
  task automatic modelStep();
    logic startEv;
    logic doorOk;
    startEv     = !startn && mPrevStartn;
    mPrevStartn = startn;
    doorOk      = door;
    if (rst) begin
      mMode = M_IDLE; mMin = 0; mSec = 0; mBeepCnt = 0; mPrevStartn = 1'b1;
    end else if (!clrn) begin
      mMode = M_IDLE; mMin = 0; mSec = 0;
    end else begin
      case (mMode)
        M_IDLE, M_ENTRY: begin
          if (mMode == M_ENTRY && startEv && doorOk && (mMin + mSec != 0)) begin
            mMode = M_COOK;
`ifdef QUICK_START_EN
          end else if (mMode == M_IDLE && startEv && doorOk && (mMin + mSec == 0)) begin
            mMin = 0; mSec = 30; mMode = M_COOK;
`endif
          end else if (keyValid && keyDigit <= 9) begin
            mMin  = (mMin % 10) * 10 + mSec / 10;
            mSec  = (mSec % 10) * 10 + int'(keyDigit);
            mMode = M_ENTRY;
          end
        end
        M_COOK: begin
          if (!stopn) begin
            mMode = M_PAUSE;
`ifdef QUICK_START_EN
          end else if (startEv && doorOk) begin
            mSec = mSec + 30;
            if (mSec >= 60) begin mSec = mSec - 60; mMin = mMin + 1; end
            if (mMin > 99) begin mMin = 99; mSec = 59; end
`endif
          end else if (!doorOk) begin
            mMode = M_PAUSE;
          end else if (tick) begin
            if (mSec == 0) begin mSec = 59; mMin = mMin - 1; end
            else mSec = mSec - 1;
            if (mMin == 0 && mSec == 0) begin mMode = M_DONE; mBeepCnt = 0; end
          end
        end
        M_PAUSE: begin
          if (startEv && doorOk && (mMin + mSec != 0)) mMode = M_COOK;
        end
        M_DONE: begin
          if (tick) begin
            mBeepCnt++;
            if (mBeepCnt == DONE_TICKS) mMode = M_IDLE;
          end
        end
        default: mMode = M_IDLE;
      endcase
    end
  endtask

  task automatic checkOutput();
    logic [15:0] expTempo;
    expTempo = {4'(mMin / 10), 4'(mMin % 10), 4'(mSec / 10), 4'(mSec % 10)};
    checkVal("tempo", tempo, expTempo);
    checkVal("zero", 16'(zero), 16'(expTempo == 16'h0000));
    checkVal("magnetron_on", 16'(magnetronOn), 16'(mMode == M_COOK));
    checkVal("beep", 16'(beep), 16'(mMode == M_DONE));
    checkVal("cozinhando", 16'(cozinhando), 16'(mMode == M_COOK || mMode == M_PAUSE));
  endtask

  task automatic applyStimulus(input logic r, input logic t, input logic sn, input logic stn,
                               input logic cn, input logic d, input logic kv, input logic [3:0] kd);
    rst = r; tick = t; startn = sn; stopn = stn; clrn = cn; door = d; keyValid = kv; keyDigit = kd;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idleCycle();           applyStimulus(0, 0, 1, 1, 1, 1, 0, 4'd0); endtask
  task automatic tickOnce();            applyStimulus(0, 1, 1, 1, 1, 1, 0, 4'd0); endtask
  task automatic startPulse();          applyStimulus(0, 0, 0, 1, 1, 1, 0, 4'd0); endtask
  task automatic clearCycle();          applyStimulus(0, 0, 1, 1, 0, 1, 0, 4'd0); endtask
  task automatic pressKey(input logic [3:0] d); applyStimulus(0, 0, 1, 1, 1, 1, 1, d); endtask

  initial begin
    // Reset
    applyStimulus(1, 0, 1, 1, 1, 1, 0, 4'd0);
    applyStimulus(1, 0, 1, 1, 1, 1, 0, 4'd0);
    checkVal("reset_tempo", tempo, 16'h0000);
    checkVal("reset_zero", 16'(zero), 16'h1);
    checkVal("reset_magnetron", 16'(magnetronOn), 16'h0);
    checkVal("reset_beep", 16'(beep), 16'h0);
    idleCycle();

    // Full cycle from 01:05
    pressKey(4'd0); pressKey(4'd1); pressKey(4'd0); pressKey(4'd5);
    checkVal("t2_entry", tempo, 16'h0105);
    startPulse();
    checkVal("t2_start_mag", 16'(magnetronOn), 16'h1);
    for (int i = 0; i < 64; i++) tickOnce();
    checkVal("t2_last_sec", tempo, 16'h0001);
    checkVal("t2_still_on", 16'(magnetronOn), 16'h1);
    tickOnce();
    checkVal("t2_end_tempo", tempo, 16'h0000);
    checkVal("t2_end_mag", 16'(magnetronOn), 16'h0);
    checkVal("t2_end_beep", 16'(beep), 16'h1);
    tickOnce(); tickOnce();
    checkVal("t2_beep_held", 16'(beep), 16'h1);
    tickOnce();
    checkVal("t2_beep_off", 16'(beep), 16'h0);

    // Door opened with a coincident tick
    clearCycle();
    pressKey(4'd1); pressKey(4'd0);
    startPulse();
    applyStimulus(0, 1, 1, 1, 1, 0, 0, 4'd0);
    checkVal("t3_pause_tempo", tempo, 16'h0010);
    checkVal("t3_pause_mag", 16'(magnetronOn), 16'h0);
    checkVal("t3_pause_cooz", 16'(cozinhando), 16'h1);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 4'd0);
    checkVal("t3_open_start", 16'(magnetronOn), 16'h0);
    idleCycle();
    startPulse();
    checkVal("t3_resume_mag", 16'(magnetronOn), 16'h1);
    checkVal("t3_resume_tempo", tempo, 16'h0010);

    // Stop, then a held start resumes once
    clearCycle();
    pressKey(4'd1); pressKey(4'd0); pressKey(4'd0);
    startPulse();
    idleCycle();
    applyStimulus(0, 0, 1, 0, 1, 1, 0, 4'd0);
    checkVal("t4_stop_mag", 16'(magnetronOn), 16'h0);
    applyStimulus(0, 0, 1, 0, 1, 1, 0, 4'd0);
    checkVal("t4_stop_in_pause", 16'(cozinhando), 16'h1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 1, 1, 0, 4'd0);
    checkVal("t4_held_mag", 16'(magnetronOn), 16'h1);
    tickOnce();
    checkVal("t4_borrow", tempo, 16'h0059);

    // Clear while cooking, then ignored start/key
    clearCycle();
    pressKey(4'd2); pressKey(4'd0);
    startPulse();
    clearCycle();
    checkVal("t5_clr_tempo", tempo, 16'h0000);
    checkVal("t5_clr_cooz", 16'(cozinhando), 16'h0);
    pressKey(4'd12);
    checkVal("t5_key12", tempo, 16'h0000);
`ifndef QUICK_START_EN
    startPulse();
    checkVal("t5_start_zero", 16'(magnetronOn), 16'h0);
    idleCycle();
`endif
    pressKey(4'd0);
    startPulse();
    checkVal("t5_entry_zero", 16'(magnetronOn), 16'h0);
    idleCycle();

`ifdef QUICK_START_EN
    clearCycle();
    startPulse();
    checkVal("t6_quick", tempo, 16'h0030);
    idleCycle();
    startPulse();
    checkVal("t6_add", tempo, 16'h0100);
    clearCycle();
    pressKey(4'd9); pressKey(4'd9); pressKey(4'd5); pressKey(4'd0);
    startPulse();
    idleCycle();
    startPulse();
    checkVal("t6_sat", tempo, 16'h9959);
`endif

    // Randomized episodes
    for (int ep = 0; ep < 25; ep++) begin
      clearCycle();
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) pressKey(4'($urandom_range(0, 9)));
      idleCycle();
      startPulse();
      for (int c = 0; c < 160; c++) begin
        applyStimulus(($urandom_range(0, 499) == 0),
                      ($urandom_range(0, 1) == 0),
                      ($urandom_range(0, 7) != 0),
                      ($urandom_range(0, 79) != 0),
                      ($urandom_range(0, 149) != 0),
                      ($urandom_range(0, 39) != 0),
                      ($urandom_range(0, 5) == 0),
                      4'($urandom_range(0, 15)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/microondas_sequencer.md
Name: microondas_sequencer

Overview:
Top-level cook sequencer for the microwave. It accepts keypad digits into a 4-digit BCD mm:ss time register and counts that time down on a 1 Hz tick. It drives the magnetron enable and the end-of-cycle beep. It owns the start/stop/clear/door policy and sits between the keypad/button front-end and the magnetron/display datapath.

Parameters:
DONE_TICKS, 3, number of tick_1hz pulses that beep stays high after the count reaches 0000 (1..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
tick_1hz  input  1  one-cycle enable pulse, once per second
startn  input  1  start button, active-low level
stopn  input  1  stop/pause button, active-low level
clrn  input  1  clear button, active-low level
porta_fechada  input  1  1 = door closed
key_valid  input  1  one-cycle strobe, key_digit valid
key_digit  input  4  keypad digit, binary 0..9
tempo  output  16  BCD {min_tens, min_units, sec_tens, sec_units}
zero  output  1  1 when tempo == 16'h0000
magnetron_on  output  1  magnetron enable
beep  output  1  end-of-cycle alarm
cozinhando  output  1  1 while in COOK or PAUSE

Behaviour:
- States: IDLE, ENTRY, COOK, PAUSE, DONE.
- Reset values: state IDLE, tempo 0000, magnetron_on 0, beep 0, cozinhando 0, zero 1, startn edge register 1, beep counter 0.
- Outputs are Moore, decoded from registered state and tempo:
  - magnetron_on = (state == COOK)
  - beep = (state == DONE)
  - zero = (tempo == 0)
- Start event: startn low in the current sample and high in the previous sample (falling edge). Holding startn low never re-triggers.
- Per-cycle priority: rst > clrn low > stopn low > start event > door open > tick > key.
- clrn low, any state: tempo <= 0000, state <= IDLE next edge. This also covers COOK, where the magnetron drops one cycle later.
- Key entry, IDLE/ENTRY only:
  - key_valid with digit 0..9 shifts left: tempo <= {tempo[11:0], digit}, and the state becomes ENTRY.
  - Digits 10..15 are ignored.
  - Keys in COOK/PAUSE/DONE are ignored.
- Start event in ENTRY or PAUSE with porta_fechada=1 and tempo != 0: state becomes COOK on the next edge.
  - Start with the door open, or with tempo == 0, is ignored.
  - Start in IDLE/COOK/DONE is ignored.
- stopn low in COOK: PAUSE next edge, tempo held. In PAUSE, stopn low has no effect; clrn is used to abort.
- COOK, porta_fechada=0: PAUSE next edge. A tick in that same cycle is discarded and there is no decrement.
- COOK, tick_1hz, door closed: BCD decrement of mm:ss.
  - sec_units 0 -> 9 with borrow into sec_tens.
  - sec_tens 0 -> 5 with borrow into minutes.
  - min_units 0 -> 9 with borrow into min_tens.
  - Entered seconds above 59 (e.g. 0099) count down literally: 99 -> 98 ... -> 00 -> borrow.
- COOK, decrement result == 0000: DONE on the same edge, so magnetron_on is low in the cycle after the final tick.
- DONE: the beep counter counts ticks. After DONE_TICKS ticks the state becomes IDLE, and beep clears on the edge of the last counted tick. clrn exits early.
- No transitions occur on tick in IDLE/ENTRY/PAUSE.

Optional Feature:
Macro QUICK_START_EN.
- Defined:
  - A start event in IDLE with tempo == 0000 and door closed loads tempo = 0030 and enters COOK.
  - A start event in COOK adds 30 s. BCD add saturates at 9959; sec_tens carry at 6.
- Undefined: both cases are ignored, as specified above.

Test Plan:
1. rst=1 for 2 cycles -> tempo=0000, zero=1, magnetron_on=0, beep=0, state IDLE.
2. Keys 0,1,0,5 then startn pulse, door closed -> tempo=0105, magnetron_on=1 one cycle after the edge. After 65 ticks: tempo=0000, magnetron_on=0, beep=1 for DONE_TICKS=3 ticks, then IDLE.
3. COOK at 0010, porta_fechada=0 with a coincident tick -> PAUSE, tempo stays 0010, magnetron_on=0. Door closed + startn pulse -> COOK resumes from 0010.
4. COOK at 0100, stopn low 1 cycle -> PAUSE. Hold startn low 5 cycles with door closed -> exactly one resume. Next tick -> 0059.
5. COOK at 0020 plus clrn low -> tempo=0000, IDLE, magnetron_on=0. Startn pulse with tempo 0000 and key 12 -> no change.
6. QUICK_START_EN: startn in IDLE at 0000 -> tempo=0030, COOK. Startn again -> 0100. At 9950, startn -> 9959.
